// File: rtl/banked_dual_port_memory_if.sv
// Request/grant bus between two independent masters and the banked dual-port memory.
// The memory side uses the slave modport; the masters (or a bench) use master.
interface banked_dual_port_memory_if #(
  parameter int WIDTH = 12,
  parameter int ADDR  = 10
) ();
  logic             i_req_a;
  logic             i_we_a;
  logic [ADDR-1:0]  i_addr_a;
  logic [WIDTH-1:0] i_din_a;
  logic             o_gnt_a;
  logic             o_rvalid_a;
  logic [WIDTH-1:0] o_dout_a;

  logic             i_req_b;
  logic             i_we_b;
  logic [ADDR-1:0]  i_addr_b;
  logic [WIDTH-1:0] i_din_b;
  logic             o_gnt_b;
  logic             o_rvalid_b;
  logic [WIDTH-1:0] o_dout_b;

  modport slave (
    input  i_req_a, i_we_a, i_addr_a, i_din_a,
    output o_gnt_a, o_rvalid_a, o_dout_a,
    input  i_req_b, i_we_b, i_addr_b, i_din_b,
    output o_gnt_b, o_rvalid_b, o_dout_b
  );

  modport master (
    output i_req_a, i_we_a, i_addr_a, i_din_a,
    input  o_gnt_a, o_rvalid_a, o_dout_a,
    output i_req_b, i_we_b, i_addr_b, i_din_b,
    input  o_gnt_b, o_rvalid_b, o_dout_b
  );
endinterface

// File: rtl/banked_dual_port_memory.sv
// Two-port memory split into BANKS low-order-interleaved banks with round-robin
// same-bank arbitration. Define BANKED_DPM_CONFLICT_CNT_EN to enable the conflict counter.
module banked_dual_port_memory #(
  parameter int WIDTH = 12,
  parameter int ADDR  = 10,
  parameter int BANKS = 4,
  parameter int CNT_W = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  banked_dual_port_memory_if.slave       bus,
  output logic [CNT_W-1:0]               o_conflict_cnt
);

  localparam int BS    = $clog2(BANKS);
  localparam int ROW_W = ADDR - BS;
  localparam int DEPTH = 1 << ROW_W;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e prio_q, prio_d;

  logic [BS-1:0]    bank_a, bank_b;
  logic [ROW_W-1:0] row_a, row_b;
  logic             conflict;
  logic             gnt_a, gnt_b;
  logic             acc_a, acc_b;
  logic             rd_a, rd_b;

  assign bank_a = bus.i_addr_a[BS-1:0];
  assign bank_b = bus.i_addr_b[BS-1:0];
  assign row_a  = bus.i_addr_a[ADDR-1:BS];
  assign row_b  = bus.i_addr_b[ADDR-1:BS];

  // Arbiter: grants depend only on req, bank and prio, so they stay live during reset.
  always_comb begin
    conflict = 1'b0;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    prio_d   = prio_q;
    conflict = bus.i_req_a && bus.i_req_b && (bank_a == bank_b);
    gnt_a    = bus.i_req_a && (!conflict || (prio_q == PRIO_A));
    gnt_b    = bus.i_req_b && (!conflict || (prio_q == PRIO_B));
    if (conflict) begin
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign bus.o_gnt_a = gnt_a;
  assign bus.o_gnt_b = gnt_b;

  // The storage has no reset, so accesses seen while reset is held are masked here.
  assign acc_a = gnt_a && i_rst_n;
  assign acc_b = gnt_b && i_rst_n;
  assign rd_a  = acc_a && !bus.i_we_a;
  assign rd_b  = acc_b && !bus.i_we_b;

  logic [WIDTH-1:0] bank_rdata [BANKS];

  for (genvar gi = 0; gi < BANKS; gi++) begin : bank_g
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             sel_a, sel_b;
    logic             wr_en, rd_en;
    logic [ROW_W-1:0] row;
    logic [WIDTH-1:0] wdata;

    // Arbitration guarantees at most one port selects a given bank per cycle.
    assign sel_a = acc_a && (bank_a == BS'(gi));
    assign sel_b = acc_b && (bank_b == BS'(gi));
    assign row   = sel_b ? row_b : row_a;
    assign wdata = sel_b ? bus.i_din_b : bus.i_din_a;
    assign wr_en = (sel_a && bus.i_we_a) || (sel_b && bus.i_we_b);
    assign rd_en = (sel_a && !bus.i_we_a) || (sel_b && !bus.i_we_b);

    always_ff @(posedge i_clk) begin
      if (wr_en) begin
        mem[row] <= wdata;
      end
      if (rd_en) begin
        rdata_q <= mem[row];
      end
    end

    assign bank_rdata[gi] = rdata_q;
  end

  logic             rvalid_a_q, rvalid_b_q;
  logic [BS-1:0]    rd_bank_a_q, rd_bank_b_q;
  logic [WIDTH-1:0] hold_a_q, hold_b_q;
  logic [WIDTH-1:0] dout_a, dout_b;

  // Fresh bank data is steered out for the rvalid cycle; otherwise the last read is held.
  assign dout_a = rvalid_a_q ? bank_rdata[rd_bank_a_q] : hold_a_q;
  assign dout_b = rvalid_b_q ? bank_rdata[rd_bank_b_q] : hold_b_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rd_bank_a_q <= '0;
      rd_bank_b_q <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
    end else begin
      rvalid_a_q <= rd_a;
      rvalid_b_q <= rd_b;
      if (rd_a) begin
        rd_bank_a_q <= bank_a;
      end
      if (rd_b) begin
        rd_bank_b_q <= bank_b;
      end
      hold_a_q <= dout_a;
      hold_b_q <= dout_b;
    end
  end

  assign bus.o_rvalid_a = rvalid_a_q;
  assign bus.o_rvalid_b = rvalid_b_q;
  assign bus.o_dout_a   = dout_a;
  assign bus.o_dout_b   = dout_b;

`ifdef BANKED_DPM_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_conflict_cnt = cnt_q;
`else
  assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_banked_dual_port_memory.sv
// Directed bench for banked_dual_port_memory: parallel access, round-robin conflicts,
// reset behaviour and counter saturation (second instance with a 2-bit counter).
module tb_banked_dual_port_memory;
  localparam int WIDTH = 12;
  localparam int ADDR  = 10;
  localparam int BANKS = 4;

`ifdef BANKED_DPM_CONFLICT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] cnt;
  logic [1:0]  cnt_sat;
  int          checks;
  int          errors;

  banked_dual_port_memory_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus_if ();
  banked_dual_port_memory_if #(.WIDTH(WIDTH), .ADDR(ADDR)) sat_if ();

  banked_dual_port_memory #(.WIDTH(WIDTH), .ADDR(ADDR), .BANKS(BANKS), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus_if.slave),
    .o_conflict_cnt (cnt)
  );

  banked_dual_port_memory #(.WIDTH(WIDTH), .ADDR(ADDR), .BANKS(BANKS), .CNT_W(2)) dut_sat (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (sat_if.slave),
    .o_conflict_cnt (cnt_sat)
  );

  // The saturation instance sees exactly the same request stream.
  assign sat_if.i_req_a  = bus_if.i_req_a;
  assign sat_if.i_we_a   = bus_if.i_we_a;
  assign sat_if.i_addr_a = bus_if.i_addr_a;
  assign sat_if.i_din_a  = bus_if.i_din_a;
  assign sat_if.i_req_b  = bus_if.i_req_b;
  assign sat_if.i_we_b   = bus_if.i_we_b;
  assign sat_if.i_addr_b = bus_if.i_addr_b;
  assign sat_if.i_din_b  = bus_if.i_din_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [ADDR-1:0] addr,
                       input logic [WIDTH-1:0] din);
    bus_if.i_req_a  = req;
    bus_if.i_we_a   = we;
    bus_if.i_addr_a = addr;
    bus_if.i_din_a  = din;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [ADDR-1:0] addr,
                       input logic [WIDTH-1:0] din);
    bus_if.i_req_b  = req;
    bus_if.i_we_b   = we;
    bus_if.i_addr_b = addr;
    bus_if.i_din_b  = din;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
  endtask

  logic exp_ga [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] exp_sat [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();

    // Reset defaults
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_a",   bus_if.o_dout_a,   32'h0);
    check("rst_dout_b",   bus_if.o_dout_b,   32'h0);
    check("rst_rvalid_a", bus_if.o_rvalid_a, 32'h0);
    check("rst_rvalid_b", bus_if.o_rvalid_b, 32'h0);
    check("rst_cnt",      cnt,               32'h0);
    rst_n = 1'b1;

    // Parallel writes then crossed reads, different banks
    set_a(1'b1, 1'b1, 10'h004, 12'hABC);
    set_b(1'b1, 1'b1, 10'h005, 12'h123);
    #1;
    check("par_wr_gnt_a", bus_if.o_gnt_a, 32'h1);
    check("par_wr_gnt_b", bus_if.o_gnt_b, 32'h1);
    tick();
    set_a(1'b1, 1'b0, 10'h005, '0);
    set_b(1'b1, 1'b0, 10'h004, '0);
    #1;
    check("par_rd_gnt_a",   bus_if.o_gnt_a,    32'h1);
    check("par_rd_gnt_b",   bus_if.o_gnt_b,    32'h1);
    check("wr_no_rvalid_a", bus_if.o_rvalid_a, 32'h0);
    tick();
    idle();
    #1;
    check("par_rvalid_a", bus_if.o_rvalid_a, 32'h1);
    check("par_rvalid_b", bus_if.o_rvalid_b, 32'h1);
    check("par_dout_a",   bus_if.o_dout_a,   32'h123);
    check("par_dout_b",   bus_if.o_dout_b,   32'hABC);
    check("par_cnt",      cnt,               32'h0);
    tick();
    check("hold_rvalid_a", bus_if.o_rvalid_a, 32'h0);
    check("hold_dout_a",   bus_if.o_dout_a,   32'h123);

    // Preload bank 2 from port A alone
    set_a(1'b1, 1'b1, 10'h002, 12'h5A5);
    tick();
    set_a(1'b1, 1'b1, 10'h006, 12'h3C3);
    tick();
    idle();

    // Same-bank reads held for 4 cycles: grants alternate A, B, A, B
    set_a(1'b1, 1'b0, 10'h002, '0);
    set_b(1'b1, 1'b0, 10'h006, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_gnt_a_%0d", k), bus_if.o_gnt_a, {31'h0, exp_ga[k]});
      check($sformatf("rr_gnt_b_%0d", k), bus_if.o_gnt_b, {31'h0, !exp_ga[k]});
      check($sformatf("rr_sat_%0d", k), cnt_sat, CNT_ON ? {30'h0, exp_sat[k]} : 32'h0);
      if (k > 0) begin
        check($sformatf("rr_rvalid_a_%0d", k), bus_if.o_rvalid_a, {31'h0, exp_ga[k-1]});
        check($sformatf("rr_rvalid_b_%0d", k), bus_if.o_rvalid_b, {31'h0, !exp_ga[k-1]});
      end
      tick();
    end
    idle();
    #1;
    check("rr_last_rvalid_a", bus_if.o_rvalid_a, 32'h0);
    check("rr_last_rvalid_b", bus_if.o_rvalid_b, 32'h1);
    check("rr_dout_a",        bus_if.o_dout_a,   32'h5A5);
    check("rr_dout_b",        bus_if.o_dout_b,   32'h3C3);
    check("rr_cnt",           cnt,               CNT_ON ? 32'd4 : 32'd0);
    check("rr_sat_final",     cnt_sat,           CNT_ON ? {30'h0, exp_sat[4]} : 32'h0);

    // Equal-address writes: A wins first, B next cycle
    set_a(1'b1, 1'b1, 10'h010, 12'h111);
    set_b(1'b1, 1'b1, 10'h010, 12'h222);
    #1;
    check("eq_gnt_a", bus_if.o_gnt_a, 32'h1);
    check("eq_gnt_b", bus_if.o_gnt_b, 32'h0);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    #1;
    check("eq_gnt_b_next", bus_if.o_gnt_b, 32'h1);
    tick();
    idle();
    set_a(1'b1, 1'b0, 10'h010, '0);
    tick();
    idle();
    #1;
    check("eq_rd_rvalid", bus_if.o_rvalid_a, 32'h1);
    check("eq_rd_dout",   bus_if.o_dout_a,   32'h222);
    check("eq_cnt",       cnt,               CNT_ON ? 32'd5 : 32'd0);

    // Reset mid-read; prio was left at B by the previous conflict
    set_a(1'b1, 1'b0, 10'h004, '0);
    #1;
    check("mid_gnt_a", bus_if.o_gnt_a, 32'h1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rvalid_a", bus_if.o_rvalid_a, 32'h0);
    check("mid_dout_a",   bus_if.o_dout_a,   32'h0);
    check("mid_cnt",      cnt,               32'h0);
    set_a(1'b1, 1'b1, 10'h004, 12'hFFF);
    #1;
    check("rst_gnt_follow", bus_if.o_gnt_a, 32'h1);
    tick();
    tick();
    check("rst_no_rvalid", bus_if.o_rvalid_a, 32'h0);
    idle();
    rst_n = 1'b1;

    // After release prio is A again and the write during reset was dropped
    set_a(1'b1, 1'b0, 10'h004, '0);
    set_b(1'b1, 1'b0, 10'h000, '0);
    #1;
    check("post_gnt_a", bus_if.o_gnt_a, 32'h1);
    check("post_gnt_b", bus_if.o_gnt_b, 32'h0);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    #1;
    check("post_rvalid_a", bus_if.o_rvalid_a, 32'h1);
    check("post_dout_a",   bus_if.o_dout_a,   32'hABC);
    check("post_gnt_b2",   bus_if.o_gnt_b,    32'h1);
    tick();
    idle();
    #1;
    check("post_rvalid_b", bus_if.o_rvalid_b, 32'h1);
    check("post_cnt",      cnt,               CNT_ON ? 32'd1 : 32'd0);
    check("post_sat",      cnt_sat,           CNT_ON ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/banked_dual_port_memory.md
# banked_dual_port_memory

Parametrised successor to the two-port RAM: a single-clock, two-port memory split into BANKS low-order-interleaved banks, so ports A and B proceed in parallel whenever they address different banks. Each port has a request/grant handshake and a registered read-valid. A round-robin arbiter resolves same-bank conflicts, and an optional counter tracks them. Sits between two independent masters and shared on-chip storage.

## Interface
- WIDTH, 12, data word width in bits.
- ADDR, 10, address width; total depth 2**ADDR words.
- BANKS, 4, bank count; power of two, 2 ≤ BANKS ≤ 2**(ADDR-1).
- CNT_W, 16, conflict counter width.
- i_clk  input  1  single clock, all logic on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_req_a / i_req_b  input  1  port request.
- i_we_a / i_we_b  input  1  1 = write, 0 = read; qualified by request.
- i_addr_a / i_addr_b  input  ADDR  word address.
- i_din_a / i_din_b  input  WIDTH  write data.
- o_gnt_a / o_gnt_b  output  1  combinational grant; transfer occurs on an edge with req&&gnt.
- o_rvalid_a / o_rvalid_b  output  1  one-cycle pulse, read data valid.
- o_dout_a / o_dout_b  output  WIDTH  registered read data.
- o_conflict_cnt  output  CNT_W  saturating same-bank conflict count.

## Operation
- Bank select is addr[BS-1:0], where BS = log2(BANKS). Row is addr[ADDR-1:BS]. Each bank holds 2**ADDR/BANKS words.
- Memory contents are not reset and are X until written.
- **No conflict** (one request, or two requests to different banks): every requester is granted in the same cycle.
- **Conflict** (both requests to the same bank): exactly one port is granted.
  - Winner is the port named by the priority pointer `prio`; prio resets to A.
  - On every conflict cycle, prio moves to the loser. Non-conflict cycles leave prio unchanged.
  - A losing master must hold req/we/addr/din stable until granted. It is granted on the next cycle at the latest, so there is no starvation.
- A conflict is counted whether or not the addresses are equal, and regardless of read/write mix.
- **Granted write**: bank[row] <= din at the edge.
- **Granted read**: dout_x <= bank[row] at the edge, and rvalid_x = 1 for that following cycle.
- Read-during-write to the same word cannot occur, because same-bank accesses are serialised by arbitration.
- A read of a word written on an earlier edge returns the new data.
- o_dout_x holds its last read value when no read completes. Writes never change o_dout.
- Grant is purely combinational from req, addr and prio. Grants are asserted only for asserted requests.

## Timing
- Grant: 0-cycle, combinational.
- Write: data committed at the edge where req&&gnt.
- Read latency: 1. Data and rvalid are present in the cycle after the granted edge.
- Throughput: one access per port per cycle when banks differ; two same-bank accesses complete in 2 cycles.
- Reset values: o_dout_a/b = 0, o_rvalid_a/b = 0, o_conflict_cnt = 0, prio = A.
- o_gnt follows requests combinationally while reset is held. Accesses during reset are discarded.
- Reset mid-operation: a read granted on the edge coincident with, or after, reset assertion produces no rvalid. Its data is lost, and a pending loser's request is forgotten.
- First access after reset release is accepted on the first rising edge with i_rst_n high.

## Configuration
- Macro BANKED_DPM_CONFLICT_CNT_EN.
- **Defined**: o_conflict_cnt increments by 1 on each conflict cycle and saturates at 2**CNT_W-1. It clears only on reset.
- **Undefined**: the counter logic is omitted and o_conflict_cnt is tied to 0. The port list is unchanged, and arbitration behaviour is identical.

## Test plan
- **Reset defaults**: hold i_rst_n=0 for 3 cycles -> o_dout_a/b=0, o_rvalid_a/b=0, o_conflict_cnt=0.
- **Parallel access, different banks**: A writes 0xABC to addr 0x004 (bank 0) while B writes 0x123 to addr 0x005 (bank 1). Both granted that cycle. Next cycle A reads 0x005 and B reads 0x004 -> one cycle later rvalid_a=rvalid_b=1, dout_a=0x123, dout_b=0xABC, cnt still 0.
- **Conflict, round-robin**: A and B both read bank 2 (addrs 0x002 and 0x006) for 4 cycles, holding stimulus. Expected:
  - grants A, B, A, B with one rvalid per cycle;
  - cnt=4 with macro defined, 0 without.
- **Equal-address writes**: both write addr 0x010, A=0x111, B=0x222. A is granted first and B next cycle. Readback of 0x010 -> 0x222.
- **Reset mid-read**: grant a read on A, then assert i_rst_n low before the next edge -> no rvalid_a, dout_a=0, prio=A after release.
- **Counter saturation** (CNT_W=2, macro defined): 6 conflict cycles -> o_conflict_cnt stays at 3 after the third conflict.
